// File: rtl/cond_logic.sv
// Conditional-execution unit: holds NZCV flags, evaluates Cond, gates PC/reg/mem writes.
// Latency: outputs are combinational (0 cycles); flag banks update on the rising CLK edge.
// Backpressure: none; the write requests are only qualified by the condition result.
module cond_logic (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic [1:0] FlagW,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite
);

  // Two independently enabled flag banks: {N,Z} and {C,V}.
  logic [1:0] flags_nz;
  logic [1:0] flags_cv;
  logic       n, z, c, v;
  logic       condex;

  assign n = flags_nz[1];
  assign z = flags_nz[0];
  assign c = flags_cv[1];
  assign v = flags_cv[0];

  // Evaluate the condition field against the stored (pre-edge) flags only.
  always_comb begin
    condex = 1'b0;
    case (Cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // Gate the decoder requests with the condition result.
  always_comb begin
    PCSrc    = PCS  & condex;
    RegWrite = RegW & condex;
    MemWrite = MemW & condex;
  end

  // NZ bank: loads ALU N,Z when enabled and the condition passes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      flags_nz <= 2'b00;
    else if (FlagW[1] & condex)
      flags_nz <= ALUFlags[3:2];
  end

  // CV bank: loads ALU C,V when enabled and the condition passes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      flags_cv <= 2'b00;
    else if (FlagW[0] & condex)
      flags_cv <= ALUFlags[1:0];
  end

endmodule

// File: tb/tb_cond_logic.sv
// Directed checks of cond_logic: reset, condition table, split flag enables, async reset.
// Stored flags are observed through the outputs by probing EQ/CS/MI/VS with FlagW=0.
// Inputs change on the falling edge; outputs are sampled shortly after.
module tb_cond_logic;

  logic       CLK;
  logic       RESET;
  logic       PCS, RegW, MemW;
  logic [1:0] FlagW;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       PCSrc, RegWrite, MemWrite;

  int total = 0;
  int bad   = 0;

  cond_logic dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .FlagW    (FlagW),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite)
  );

  // 20 ns period: rising edges at 10, 30, 50 ...
  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Compare the three gated outputs {PCSrc,RegWrite,MemWrite}.
  task automatic chk_out(input string tag, input logic [2:0] exp);
    #1;
    chk(tag, {1'b0, PCSrc, RegWrite, MemWrite}, {1'b0, exp});
  endtask

  // Recover stored {N,Z,C,V} via EQ/CS/MI/VS probes, then restore inputs.
  task automatic chk_flags(input string tag, input logic [3:0] exp);
    logic [3:0] sv_cond;
    logic [1:0] sv_fw;
    logic       sv_pcs;
    logic [3:0] obs;
    sv_cond = Cond; sv_fw = FlagW; sv_pcs = PCS;
    FlagW = 2'b00; PCS = 1'b1;
    Cond = 4'b0100; #1; obs[3] = PCSrc;
    Cond = 4'b0000; #1; obs[2] = PCSrc;
    Cond = 4'b0010; #1; obs[1] = PCSrc;
    Cond = 4'b0110; #1; obs[0] = PCSrc;
    Cond = sv_cond; FlagW = sv_fw; PCS = sv_pcs;
    chk(tag, obs, exp);
  endtask

  task automatic edge_then_neg();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Load flags through an AL instruction with both banks enabled.
  task automatic load_flags(input logic [3:0] f);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    edge_then_neg();
    FlagW = 2'b00;
  endtask

  initial begin
    RESET = 1'b1;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
    FlagW = 2'b11; Cond = 4'b0000; ALUFlags = 4'b0010;

    // Reset: EQ fails with Z=0, even while RESET is held.
    @(negedge CLK);
    chk_out("reset_eq_out", 3'b000);
    chk_flags("reset_flags", 4'b0000);
    RESET = 1'b0;
    chk_out("post_reset_eq_out", 3'b000);
    edge_then_neg();
    chk_flags("eq_fail_no_update", 4'b0000);

    // NE passes on old flags, then C is set.
    Cond = 4'b0001; ALUFlags = 4'b0010; FlagW = 2'b11;
    chk_out("ne_out", 3'b111);
    edge_then_neg();
    chk_flags("ne_update", 4'b0010);

    // CS passes with C=1, loads V only; then CS fails.
    Cond = 4'b0010; ALUFlags = 4'b0001;
    chk_out("cs_out", 3'b111);
    edge_then_neg();
    chk_flags("cs_update", 4'b0001);
    chk_out("cs_after_out", 3'b000);

    // Split enables from a cleared state.
    RESET = 1'b1; #1; RESET = 1'b0;
    chk_flags("reset_pulse", 4'b0000);
    Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b10;
    edge_then_neg();
    chk_flags("nz_only", 4'b1100);
    FlagW = 2'b01; ALUFlags = 4'b0011;
    edge_then_neg();
    chk_flags("cv_only", 4'b1111);

    // Failed condition suppresses both banks even with FlagW=11.
    Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b0000;
    chk_out("ne_fail_out", 3'b000);
    edge_then_neg();
    chk_flags("fail_no_update", 4'b1111);

    // Async reset between edges.
    FlagW = 2'b00;
    #2 RESET = 1'b1;
    #2 RESET = 1'b0;
    chk_flags("async_reset", 4'b0000);
    Cond = 4'b0000;
    chk_out("async_eq_out", 3'b000);

    // Signed compares with N=1, V=0.
    load_flags(4'b1000);
    Cond = 4'b1011; chk_out("lt_n1v0", 3'b111);
    Cond = 4'b1010; chk_out("ge_n1v0", 3'b000);
    Cond = 4'b0101; chk_out("pl_n1",   3'b000);

    // Z=1.
    load_flags(4'b0100);
    Cond = 4'b1100; chk_out("gt_z1", 3'b000);
    Cond = 4'b1101; chk_out("le_z1", 3'b111);
    Cond = 4'b1001; chk_out("ls_z1", 3'b111);

    // C=1, Z=0.
    load_flags(4'b0010);
    Cond = 4'b1000; chk_out("hi_c1", 3'b111);
    Cond = 4'b0011; chk_out("cc_c1", 3'b000);
    Cond = 4'b1111; chk_out("nv",    3'b000);

    // V=1, N=0.
    load_flags(4'b0001);
    Cond = 4'b0111; chk_out("vc_v1", 3'b000);
    Cond = 4'b1010; chk_out("ge_n0v1", 3'b000);
    Cond = 4'b1100; chk_out("gt_n0v1", 3'b000);
    Cond = 4'b1101; chk_out("le_n0v1", 3'b111);

    // Per-request gating.
    PCS = 1'b1; RegW = 1'b0; MemW = 1'b1;
    Cond = 4'b1110; chk_out("al_mixed", 3'b101);
    Cond = 4'b1111; chk_out("nv_mixed", 3'b000);
    PCS = 1'b0; RegW = 1'b1; MemW = 1'b0;
    Cond = 4'b0111; chk_out("vc_fail_mixed", 3'b000);
    Cond = 4'b1011; chk_out("lt_mixed", 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
